// File: rtl/regfile_arb_pkg.sv
// Purpose: shared types and helpers for the register-file port arbiter.
//   state_e : FSM encoding (ST_CLEAR while zeroing the array, ST_RUN otherwise)
//   clog2   : pointer-width helper for the round-robin arbiters
package regfile_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Returns the number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter with an internal priority pointer.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset (pointer -> 0)
//   req        : per-requester request vector
//   en         : grants are only issued while en=1
//   gnt        : one-hot grant (combinational from req, en and pointer)
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int nreq = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [nreq-1:0] req,
    input  logic            en,
    output logic [nreq-1:0] gnt
);

    localparam int PW = clog2(nreq);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    // Search upward from the pointer, wrapping modulo nreq; the first hit wins
    // and the pointer moves just past it so that requester drops to lowest priority.
    always_comb begin
        int j;
        // NOTE: every variable written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        j     = 0;
        gnt   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        for (int i = 0; i < nreq; i++) begin
            j = int'(ptr_q) + i;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if (en && !found && req[j[PW-1:0]]) begin
                found            = 1'b1;
                gnt[j[PW-1:0]]   = 1'b1;
                ptr_d            = (j == nreq - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Purpose: shares the single read and single write port of a register file
//   among nreq requesters with independent round-robin arbitration, and zeroes
//   the whole array after reset and on CLEAR_REQ while holding requesters off.
// Ports:
//   CLK, RST_N                         : clock, async active-low reset
//   RD_REQ_VALID/INDEX, RD_REQ_READY   : read request channel (one-hot grant)
//   RD_RESP_DATA, RD_RESP_VALID        : registered read response, 1-cycle latency
//   WR_REQ_VALID/INDEX/DATA, WR_REQ_READY : write request channel (one-hot grant)
//   CLEAR_REQ, CLEAR_DONE              : clear pass request / idle-in-RUN flag
//   OOR_ERR                            : sticky out-of-range index flag
//   RF_READ_INDEX, RF_READ_DATA        : register-file read port (combinational read)
//   RF_WRITE_EN/INDEX/DATA             : register-file write port
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int width = 32,
    parameter int n     = 5,
    parameter int size  = 32,
    parameter int nreq  = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [nreq-1:0]       RD_REQ_VALID,
    input  logic [nreq*n-1:0]     RD_REQ_INDEX,
    output logic [nreq-1:0]       RD_REQ_READY,
    output logic [width-1:0]      RD_RESP_DATA,
    output logic [nreq-1:0]       RD_RESP_VALID,
    input  logic [nreq-1:0]       WR_REQ_VALID,
    input  logic [nreq*n-1:0]     WR_REQ_INDEX,
    input  logic [nreq*width-1:0] WR_REQ_DATA,
    output logic [nreq-1:0]       WR_REQ_READY,
    input  logic                  CLEAR_REQ,
    output logic                  CLEAR_DONE,
    output logic                  OOR_ERR,
    output logic [n-1:0]          RF_READ_INDEX,
    input  logic [width-1:0]      RF_READ_DATA,
    output logic                  RF_WRITE_EN,
    output logic [n-1:0]          RF_WRITE_INDEX,
    output logic [width-1:0]      RF_WRITE_DATA
);

    // One extra bit so size == 2**n is representable in the range compare.
    localparam logic [n:0]   SIZE_L   = (n + 1)'(size);
    localparam logic [n-1:0] CNT_LAST = n'(size - 1);

    state_e             state_q, state_d;
    logic [n-1:0]       cnt_q, cnt_d;
    logic [width-1:0]   resp_data_q;
    logic [nreq-1:0]    resp_valid_q;
    logic               oor_q;

    logic               run;
    logic [nreq-1:0]    rd_gnt, wr_gnt;
    logic               rd_any, wr_any, rd_oor, wr_oor;
    logic [n-1:0]       rd_idx, wr_idx;
    logic [width-1:0]   wr_data;

    assign run = (state_q == ST_RUN);

    rr_arbiter #(.nreq(nreq)) u_rd_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (RD_REQ_VALID),
        .en    (run),
        .gnt   (rd_gnt)
    );

    rr_arbiter #(.nreq(nreq)) u_wr_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (WR_REQ_VALID),
        .en    (run),
        .gnt   (wr_gnt)
    );

    // Grants are one-hot, so an OR-style mux selects the granted fields.
    always_comb begin
        rd_idx  = '0;
        wr_idx  = '0;
        wr_data = '0;
        for (int i = 0; i < nreq; i++) begin
            if (rd_gnt[i]) begin
                rd_idx = RD_REQ_INDEX[i*n +: n];
            end
            if (wr_gnt[i]) begin
                wr_idx  = WR_REQ_INDEX[i*n +: n];
                wr_data = WR_REQ_DATA[i*width +: width];
            end
        end
    end

    assign rd_any = |rd_gnt;
    assign wr_any = |wr_gnt;
    assign rd_oor = rd_any && ({1'b0, rd_idx} >= SIZE_L);
    assign wr_oor = wr_any && ({1'b0, wr_idx} >= SIZE_L);

    // FSM next state: CLEAR walks cnt 0..size-1 then enters RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + n'(1);
                end
            end
            ST_RUN: begin
                if (CLEAR_REQ) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Register-file write port: the clear pass owns it outside RUN.
    always_comb begin
        RF_WRITE_EN    = wr_any && !wr_oor;
        RF_WRITE_INDEX = wr_idx;
        RF_WRITE_DATA  = wr_data;
        if (!run) begin
            RF_WRITE_EN    = 1'b1;
            RF_WRITE_INDEX = cnt_q;
            RF_WRITE_DATA  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
            oor_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= rd_gnt;
            // Data is held between grants; out-of-range reads return zero.
            if (rd_any) begin
                resp_data_q <= rd_oor ? '0 : RF_READ_DATA;
            end
            // Starting a clear pass wins over a same-cycle range error.
            if (run && CLEAR_REQ) begin
                oor_q <= 1'b0;
            end else if (rd_oor || wr_oor) begin
                oor_q <= 1'b1;
            end
        end
    end

    assign RD_REQ_READY  = rd_gnt;
    assign WR_REQ_READY  = wr_gnt;
    assign RD_RESP_DATA  = resp_data_q;
    assign RD_RESP_VALID = resp_valid_q;
    assign CLEAR_DONE    = run;
    assign OOR_ERR       = oor_q;
    assign RF_READ_INDEX = rd_idx;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a 32-entry register-file model.
// Index width is 6 so that out-of-range indices (e.g. 40) are expressible.
module tb_regfile_port_arbiter;

    localparam int W  = 32;
    localparam int N  = 6;
    localparam int SZ = 32;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   rd_valid, rd_ready, resp_valid, wr_valid, wr_ready;
    logic [NR*N-1:0] rd_index, wr_index;
    logic [NR*W-1:0] wr_data_bus;
    logic [W-1:0]    resp_data, rf_rdata, rf_wdata;
    logic            clear_req, clear_done, oor;
    logic [N-1:0]    rf_ridx, rf_widx;
    logic            rf_we;

    logic [W-1:0]    mem [SZ] = '{default: 32'hA5A5_A5A5};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.width(W), .n(N), .size(SZ), .nreq(NR)) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .RD_REQ_VALID   (rd_valid),
        .RD_REQ_INDEX   (rd_index),
        .RD_REQ_READY   (rd_ready),
        .RD_RESP_DATA   (resp_data),
        .RD_RESP_VALID  (resp_valid),
        .WR_REQ_VALID   (wr_valid),
        .WR_REQ_INDEX   (wr_index),
        .WR_REQ_DATA    (wr_data_bus),
        .WR_REQ_READY   (wr_ready),
        .CLEAR_REQ      (clear_req),
        .CLEAR_DONE     (clear_done),
        .OOR_ERR        (oor),
        .RF_READ_INDEX  (rf_ridx),
        .RF_READ_DATA   (rf_rdata),
        .RF_WRITE_EN    (rf_we),
        .RF_WRITE_INDEX (rf_widx),
        .RF_WRITE_DATA  (rf_wdata)
    );

    // Register-file model: combinational read, write at the clock edge.
    assign rf_rdata = (rf_ridx < N'(SZ)) ? mem[rf_ridx[4:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (rf_we && rf_widx < N'(SZ)) begin
            mem[rf_widx[4:0]] <= rf_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [N-1:0] idx);
        rd_index[i*N +: N] = idx;
    endtask

    task automatic set_wr(input int i, input logic [N-1:0] idx, input logic [W-1:0] d);
        wr_index[i*N +: N]    = idx;
        wr_data_bus[i*W +: W] = d;
    endtask

    task automatic check_mem_zero(input string tag);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < SZ; i++) begin
            nz = nz | (mem[i] != '0);
        end
        check(tag, nz, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rd_valid    = '1;
        wr_valid    = '1;
        rd_index    = '0;
        wr_index    = '0;
        wr_data_bus = '0;
        clear_req   = 1'b0;

        // Reset state, with every requester asking.
        #12;
        check("rst_done", clear_done, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_oor", oor, 0);
        check("rst_ready", {rd_ready, wr_ready}, 0);

        // Initial clear pass: 32 cycles, indices 0..31, data 0, no grants.
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < SZ; c++) begin
            check("clr_we", rf_we, 1);
            check("clr_idx", rf_widx, c);
            check("clr_data", rf_wdata, 0);
            check("clr_done", clear_done, 0);
            check("clr_ready", {rd_ready, wr_ready}, 0);
            if (c == SZ - 1) begin
                rd_valid = '0;
                wr_valid = '0;
            end
            tick();
        end
        check("clr_done_33", clear_done, 1);
        check_mem_zero("clr_mem_zero");

        // Four writers at once: grants 0,1,2,3 preload idx 1..4.
        for (int i = 0; i < NR; i++) set_wr(i, N'(i + 1), 32'h1000_0000 + i);
        wr_valid = '1;
        #1;
        for (int k = 0; k < NR; k++) begin
            check("wr_rr_gnt", wr_ready, 1 << k);
            check("wr_rr_idx", rf_widx, k + 1);
            tick();
        end
        wr_valid = '0;

        // Four readers held high: grants 0,1,2,3,0; responses one cycle later.
        for (int i = 0; i < NR; i++) set_rd(i, N'(i + 1));
        rd_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rd_rr_gnt", rd_ready, 1 << (k % NR));
            check("rd_rr_idx", rf_ridx, (k % NR) + 1);
            if (k > 0) begin
                check("rd_rr_rvalid", resp_valid, 1 << ((k - 1) % NR));
                check("rd_rr_rdata", resp_data, 32'h1000_0000 + ((k - 1) % NR));
            end
            tick();
        end
        check("rd_rr_rvalid_last", resp_valid, 4'b0001);
        check("rd_rr_rdata_last", resp_data, 32'h1000_0000);
        rd_valid = '0;
        tick();
        check("rd_pulse_low", resp_valid, 0);
        check("rd_hold_data", resp_data, 32'h1000_0000);

        // Same-cycle write (writer 2) and read (reader 1) of idx 5.
        set_rd(1, 6'd5);
        set_wr(2, 6'd5, 32'hDEAD_BEEF);
        rd_valid = 4'b0010;
        wr_valid = 4'b0100;
        #1;
        check("rw_rd_gnt", rd_ready, 4'b0010);
        check("rw_wr_gnt", wr_ready, 4'b0100);
        check("rw_we", rf_we, 1);
        check("rw_widx", rf_widx, 5);
        check("rw_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        rd_valid = '0;
        wr_valid = '0;
        check("rw_old_valid", resp_valid, 4'b0010);
        check("rw_old_data", resp_data, 0);
        rd_valid = 4'b0010;
        #1;
        check("rw_reread_gnt", rd_ready, 4'b0010);
        tick();
        rd_valid = '0;
        check("rw_new_data", resp_data, 32'hDEAD_BEEF);

        // Out-of-range write then read of idx 40.
        set_wr(0, 6'd40, 32'h1234_5678);
        wr_valid = 4'b0001;
        #1;
        check("oor_wr_gnt", wr_ready, 4'b0001);
        check("oor_we", rf_we, 0);
        check("oor_before", oor, 0);
        tick();
        wr_valid = '0;
        check("oor_set", oor, 1);
        check("oor_no_alias", mem[8], 0);
        set_rd(3, 6'd40);
        rd_valid = 4'b1000;
        #1;
        check("oor_rd_gnt", rd_ready, 4'b1000);
        check("oor_ridx", rf_ridx, 40);
        tick();
        rd_valid = '0;
        check("oor_rd_valid", resp_valid, 4'b1000);
        check("oor_rd_data", resp_data, 0);
        check("oor_sticky", oor, 1);

        // CLEAR_REQ with writers active: the in-flight grant commits first.
        set_wr(1, 6'd7, 32'h77);
        set_wr(2, 6'd9, 32'h99);
        set_rd(0, 6'd7);
        wr_valid  = 4'b0110;
        clear_req = 1'b1;
        #1;
        check("cr_wr_gnt", wr_ready, 4'b0010);
        check("cr_widx", rf_widx, 7);
        tick();
        clear_req = 1'b0;
        rd_valid  = 4'b0001;
        check("cr_commit", mem[7], 32'h77);
        check("cr_oor_clr", oor, 0);
        check("cr_done", clear_done, 0);
        for (int c = 0; c < SZ; c++) begin
            check("cr_ready", {rd_ready, wr_ready}, 0);
            check("cr_idx", rf_widx, c);
            check("cr_we_data", {rf_we, rf_wdata}, {1'b1, 32'h0});
            if (c == SZ - 1) begin
                rd_valid = '0;
                wr_valid = '0;
            end
            tick();
        end
        check("cr_done_after", clear_done, 1);
        check_mem_zero("cr_mem_zero");
        rd_valid = 4'b0001;
        #1;
        check("cr_rd_gnt", rd_ready, 4'b0001);
        tick();
        rd_valid = '0;
        check("cr_rd_valid", resp_valid, 4'b0001);
        check("cr_rd_data", resp_data, 0);
        check("cr_oor_after", oor, 0);

        // Load a recognisable response, then reset at clear cycle 10.
        set_wr(2, 6'd3, 32'hCAFE_F00D);
        wr_valid = 4'b0100;
        #1;
        check("r6_wr_gnt", wr_ready, 4'b0100);
        tick();
        wr_valid = '0;
        set_rd(1, 6'd3);
        rd_valid = 4'b0010;
        #1;
        check("r6_rd_gnt", rd_ready, 4'b0010);
        tick();
        rd_valid = '0;
        check("r6_rd_data", resp_data, 32'hCAFE_F00D);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        check("r6_cnt10", rf_widx, 10);
        check("r6_data_held", resp_data, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check("r6_async_idx", rf_widx, 0);
        check("r6_async_data", resp_data, 0);
        check("r6_async_done", clear_done, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("r6_restart0", rf_widx, 0);
        tick();
        check("r6_restart1", rf_widx, 1);
        repeat (30) tick();
        check("r6_cnt31", {clear_done, rf_widx}, {1'b0, 6'd31});
        tick();
        check("r6_done", clear_done, 1);

        // Reset with a read granted but not yet responded: response dropped.
        set_wr(0, 6'd50, 32'h1);
        wr_valid = 4'b0001;
        #1;
        tick();
        wr_valid = '0;
        check("r7_oor_set", oor, 1);
        set_rd(0, 6'd3);
        rd_valid = 4'b0001;
        #1;
        check("r7_rd_gnt", rd_ready, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("r7_oor_rst", oor, 0);
        check("r7_ready_rst", rd_ready, 0);
        tick();
        check("r7_no_resp", resp_valid, 0);
        rst_n    = 1'b1;
        rd_valid = '0;
        #1;
        check("r7_done", clear_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
